w_update_seq: RTL and testbench
===============================

Name: w_update_seq

Overview:
- Time-multiplexed LMS weight-update sequencer for the N-tap linear (FIR) section of the spline adaptive filter.
- Owns the N-entry input delay line and the N-entry weight register file.
- Sweeps one shared multiply-round-accumulate lane across all taps, one tap per clock, for each accepted mu*error value.
- Exposes an asynchronous-read weight port to the filtering datapath.

Parameters:
- WIDTH, 16, sample/weight/mu_error word width (signed two's complement).
- QP, 12, fractional bits (Q(WIDTH-QP).QP).
- NTAPS, 4, number of taps (>=2).
- AW, 2, address width (= clog2(NTAPS)).
- W0_INIT, 16'h1000, reset value of tap 0 (1.0). All other taps reset to 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- x_in  in  WIDTH  new input sample
- x_valid  in  1  x_in offered
- x_ready  out  1  sample accepted when x_valid&&x_ready
- mu_error  in  WIDTH  step-scaled error for one update sweep
- err_valid  in  1  start a sweep with mu_error
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep finished
- overrun  out  1  sticky: err_valid arrived while busy
- clr_overrun  in  1  synchronous clear of overrun
- rd_addr  in  AW  weight read address
- rd_data  out  WIDTH  weight[rd_addr], combinational read

Behaviour:
- Reset (async, active-high): state=IDLE, tap index=0, delay line all 0, weight[0]=W0_INIT, others 0, busy=0, done=0, overrun=0.
- FSM states: IDLE, SWEEP.
- Interface: clock port clk; reset port reset, asynchronous, active-high.
- IDLE:
  - x_ready = !err_valid, so an error has priority.
  - On x_valid&&x_ready: shift the delay line; x[0]<=x_in, x[i]<=x[i-1]; the oldest sample is discarded.
  - On err_valid: latch mu_error into mu_r, idx<=0, go to SWEEP, busy=1 from the next cycle.
- SWEEP:
  - x_ready=0 and the delay line is frozen.
  - Each cycle: weight[idx] <= weight[idx] + upd(x[idx], mu_r); idx increments.
  - Once idx==NTAPS-1 has been written, the same edge sets state=IDLE, busy=0, done=1.
  - done is registered and stays high exactly one cycle.
  - Latency from the err_valid edge to the done-high cycle: NTAPS+1 cycles. A sweep takes exactly NTAPS clocks.
- err_valid while busy: request dropped, overrun<=1. The sweep in progress is unaffected.
- overrun:
  - Stays high until clr_overrun.
  - If clr_overrun and a new overrun event occur in the same cycle, overrun stays 1.
- upd(x, m) arithmetic:
  - Full product p = x*m, signed, 2*WIDTH bits.
  - Rounded: p + 2^(QP-1).
  - Result: bits [QP+WIDTH-1:QP].
  - Accumulation wraps modulo 2^WIDTH; no saturation.
- rd_data reflects a write on the cycle after the writing edge. Reads during SWEEP are legal and may return pre- or post-update values per tap.
- Reset mid-sweep: everything returns immediately to reset values, and no done pulse is produced for the aborted sweep.
- x_valid with x_ready=0: sample not taken. The source must hold it.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SWEEP)
  - default WIDTH/QP
  - helper function for the round/extract step, so it is bit-identical to the other update blocks.
- One sub-module, w_update_lane: combinational multiply, round, extract, add. Inputs x, mu, w_old; output w_new; parameters WIDTH and QP.
- The sequencer instantiates one lane, driven by muxes on idx.

Test Plan (NTAPS=4, QP=12, WIDTH=16):
- Reset -> rd_data at addr 0..3 = 0x1000, 0, 0, 0; busy=0, done=0, overrun=0, x_ready=1.
- Shift 0x1000 then 0x0800, then err_valid with mu_error=0x0400 -> busy for 4 cycles, done 1-cycle pulse, weights = 0x1200, 0x0400, 0x0000, 0x0000.
- Rounding: line x[0]=0x0001, mu=0x0800 -> tap0 += 1. Second sweep with x[0]=0xFFFF, mu=0x0800 -> tap0 += 0.
- err_valid pulsed on the 2nd cycle of a sweep -> overrun=1; weights show only one sweep's update. clr_overrun -> overrun=0.
- x_valid and err_valid together in IDLE -> x_ready=0, no shift, sweep runs on old line; x is accepted in the first IDLE cycle after done.
- Assert reset during the 3rd sweep cycle -> weights, line and flags at reset values immediately; no done pulse; next sweep behaves as from reset.

Source files
------------

// File: rtl/w_update_seq_pkg.sv
// Shared definitions for the LMS weight-update sequencer: state encoding,
// default word format and the round/extract step used by every update lane.
package w_update_seq_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int QP_DEF    = 12;
    localparam int NTAPS_DEF = 4;
    localparam int AW_DEF    = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // Round-half-up a full-width product and drop qp fractional bits.
    // The caller keeps the low WIDTH bits of the result, which equals
    // bits [qp+WIDTH-1:qp] of (p + 2^(qp-1)). Valid for WIDTH <= 32, qp >= 1.
    function automatic logic [31:0] round_extract(input logic signed [63:0] p,
                                                  input int unsigned qp);
        logic signed [63:0] r;
        r = p + (64'sd1 <<< (qp - 1));
        r = r >>> qp;
        return r[31:0];
    endfunction

endpackage

// File: rtl/w_update_seq_if.sv
// Bus bundle between the sequencer and its environment.
//
// Handshakes:
//   x_valid/x_ready : a sample moves on a rising edge where both are high;
//                     while x_valid is high and x_ready low, the source
//                     holds x_in stable.
//   err_valid       : single-cycle request, no ready. Accepted in IDLE; if the
//                     sequencer is busy the request is dropped and overrun set.
//   done            : one-cycle pulse when a sweep has written its last tap.
//   rd_addr/rd_data : combinational weight read, no handshake.
interface w_update_seq_if
    import w_update_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
);
    logic [WIDTH-1:0] x_in;
    logic             x_valid;
    logic             x_ready;
    logic [WIDTH-1:0] mu_error;
    logic             err_valid;
    logic             busy;
    logic             done;
    logic             overrun;
    logic             clr_overrun;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    state_e           state_dbg;

    modport master (
        output x_in, x_valid, mu_error, err_valid, clr_overrun, rd_addr,
        input  x_ready, busy, done, overrun, rd_data, state_dbg
    );

    modport slave (
        input  x_in, x_valid, mu_error, err_valid, clr_overrun, rd_addr,
        output x_ready, busy, done, overrun, rd_data, state_dbg
    );
endinterface

// File: rtl/w_update_seq_lane.sv
// One multiply-round-accumulate lane: w_new = w_old + round(x*mu >> QP),
// wrapping modulo 2^WIDTH.
module w_update_lane
    import w_update_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int QP    = QP_DEF
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] mu,
    input  logic [WIDTH-1:0] w_old,
    output logic [WIDTH-1:0] w_new
);
    logic signed [2*WIDTH-1:0] prod;
    logic        [WIDTH-1:0]   inc;

    // Full signed product, then shared rounding step, then wrapping add.
    always_comb begin
        prod  = $signed(x) * $signed(mu);
        inc   = WIDTH'(round_extract(64'(prod), QP));
        w_new = w_old + inc;
    end
endmodule

// File: rtl/w_update_seq.sv
// Time-multiplexed LMS weight-update sequencer. Holds the input delay line
// and weight file, and walks one shared update lane across all taps, one tap
// per clock, for each accepted mu*error value.
module w_update_seq
    import w_update_seq_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEF,
    parameter int               QP      = QP_DEF,
    parameter int               NTAPS   = NTAPS_DEF,
    parameter int               AW      = AW_DEF,
    parameter logic [WIDTH-1:0] W0_INIT = 16'h1000
) (
    input  logic           clk,
    input  logic           reset,
    w_update_seq_if.slave  bus
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] mu_q, mu_d;
    logic [WIDTH-1:0] x_q [NTAPS];
    logic [WIDTH-1:0] x_d [NTAPS];
    logic [WIDTH-1:0] w_q [NTAPS];
    logic [WIDTH-1:0] w_d [NTAPS];
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] lane_w_new;

    // The single update lane sees whichever tap idx currently points at.
    w_update_lane #(
        .WIDTH (WIDTH),
        .QP    (QP)
    ) u_lane (
        .x     (x_q[idx_q]),
        .mu    (mu_q),
        .w_old (w_q[idx_q]),
        .w_new (lane_w_new)
    );

    // Error requests win over samples; nothing is taken while sweeping.
    assign bus.x_ready   = (state_q == ST_IDLE) && !bus.err_valid;
    assign bus.busy      = (state_q == ST_SWEEP);
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;
    assign bus.rd_data   = w_q[bus.rd_addr];
    assign bus.state_dbg = state_q;

    // Next-state logic: delay-line shift in IDLE, one tap update per SWEEP cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mu_d      = mu_q;
        x_d       = x_q;
        w_d       = w_q;
        done_d    = 1'b0;
        overrun_d = overrun_q && !bus.clr_overrun;

        case (state_q)
            ST_IDLE: begin
                if (bus.err_valid) begin
                    mu_d    = bus.mu_error;
                    idx_d   = '0;
                    state_d = ST_SWEEP;
                end else if (bus.x_valid && bus.x_ready) begin
                    x_d[0] = bus.x_in;
                    for (int i = 1; i < NTAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                end
            end
            ST_SWEEP: begin
                w_d[idx_q] = lane_w_new;
                // A new event outranks a same-cycle clear.
                if (bus.err_valid) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset restores tap 0 to unity gain and clears the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            mu_q      <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            w_q[0]    <= W0_INIT;
            x_q[0]    <= '0;
            for (int i = 1; i < NTAPS; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mu_q      <= mu_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < NTAPS; i++) begin
                w_q[i] <= w_d[i];
                x_q[i] <= x_d[i];
            end
        end
    end
endmodule

// File: tb/tb_w_update_seq.sv
// Bench for w_update_seq: directed scenarios plus random shift/sweep traffic,
// checked against a plain arithmetic model of the LMS update.
module tb_w_update_seq;
    import w_update_seq_pkg::*;

    localparam int NT = 4;

    logic clk;
    logic reset;

    w_update_seq_if #(.WIDTH(16), .AW(2)) bus ();

    w_update_seq #(
        .WIDTH   (16),
        .QP      (12),
        .NTAPS   (NT),
        .AW      (2),
        .W0_INIT (16'h1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [63:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int req_cnt = 0;
    int exp_done = 0;
    int done_seen = 0;

    // Reference model: weights and delay line as plain arrays
    logic [15:0] m_w[NT];
    logic [15:0] m_x[NT];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [15:0] ref_upd(logic [15:0] x, logic [15:0] m);
        longint p;
        p = longint'($signed(x)) * longint'($signed(m));
        p = (p + 2048) >>> 12;
        return p[15:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) begin
            m_w[i] = 16'h0000;
            m_x[i] = 16'h0000;
        end
        m_w[0] = 16'h1000;
    endfunction

    function automatic void model_shift(logic [15:0] v);
        for (int i = NT - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = v;
    endfunction

    function automatic void model_sweep(logic [15:0] mu);
        for (int i = 0; i < NT; i++) m_w[i] = m_w[i] + ref_upd(m_x[i], mu);
    endfunction

    function automatic logic [63:0] pack_model();
        return {m_w[3], m_w[2], m_w[1], m_w[0]};
    endfunction

    // Monitor: owns rd_addr; checks all weights on every done pulse and on
    // explicit read requests from the driver.
    task automatic read_weights(output logic [63:0] v);
        v = '0;
        for (int a = 0; a < NT; a++) begin
            bus.rd_addr = 2'(a);
            #1;
            v[16*a +: 16] = bus.rd_data;
        end
    endtask

    initial begin
        int served;
        logic [63:0] got;
        served = 0;
        bus.rd_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1 || req_cnt != served) begin
                if (bus.done === 1'b1) done_seen++;
                else served++;
                read_weights(got);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", got, 64'hx);
                end else begin
                    check("weights", got, exp_q.pop_front());
                end
            end
        end
    end

    // Driver tasks
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        check("rst_x_ready", 64'(bus.x_ready), 64'd1);
        model_reset();
        exp_q.push_back(pack_model());
        req_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_shift(input logic [15:0] v);
        @(negedge clk);
        bus.x_in = v;
        bus.x_valid = 1'b1;
        #1;
        check("x_ready_idle", 64'(bus.x_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
        model_shift(v);
    endtask

    // err_at: sweep cycle at which an extra err_valid is pulsed (0 = none)
    // clr_with: also pulse clr_overrun alongside that extra request
    // with_x: offer a sample together with err_valid and hold it until taken
    // abort_at: sweep cycle at which reset is asserted (0 = none)
    task automatic do_sweep(input logic [15:0] mu, input int err_at, input bit clr_with,
                            input bit with_x, input logic [15:0] xv, input int abort_at);
        int cnt;
        int busy_cnt;
        bit got_done;
        @(negedge clk);
        bus.mu_error = mu;
        bus.err_valid = 1'b1;
        if (with_x) begin
            bus.x_in = xv;
            bus.x_valid = 1'b1;
            #1;
            check("x_ready_err_prio", 64'(bus.x_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.err_valid = 1'b0;
        bus.mu_error = 16'($urandom_range(0, 65535));
        model_sweep(mu);
        if (abort_at == 0) begin
            exp_q.push_back(pack_model());
            exp_done++;
        end
        cnt = 0;
        busy_cnt = 0;
        got_done = 1'b0;
        while (!got_done && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (abort_at != 0 && cnt == abort_at) begin
                apply_reset();
                check("no_done_after_abort", 64'(bus.done), 64'd0);
                return;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (with_x && bus.busy === 1'b1)
                check("x_ready_busy", 64'(bus.x_ready), 64'd0);
            if (err_at != 0 && cnt == err_at) begin
                bus.err_valid = 1'b1;
                bus.mu_error = 16'($urandom_range(0, 65535));
                bus.clr_overrun = clr_with;
            end else begin
                bus.err_valid = 1'b0;
                bus.clr_overrun = 1'b0;
            end
            if (bus.done === 1'b1) got_done = 1'b1;
        end
        bus.err_valid = 1'b0;
        bus.clr_overrun = 1'b0;
        check("done_seen", 64'(got_done), 64'd1);
        check("done_latency", 64'(cnt), 64'(NT + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(NT));
        if (with_x) begin
            check("x_ready_after_done", 64'(bus.x_ready), 64'd1);
            @(posedge clk);
            #1;
            bus.x_valid = 1'b0;
            model_shift(xv);
        end
    endtask

    task automatic clear_overrun();
        @(negedge clk);
        bus.clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_overrun = 1'b0;
        check("overrun_cleared", 64'(bus.overrun), 64'd0);
    endtask

    // Main sequence
    initial begin
        reset = 1'b1;
        bus.x_in = '0;
        bus.x_valid = 1'b0;
        bus.mu_error = '0;
        bus.err_valid = 1'b0;
        bus.clr_overrun = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Basic sweep: expect 0x1200, 0x0400, 0, 0
        do_shift(16'h1000);
        do_shift(16'h0800);
        do_sweep(16'h0400, 0, 1'b0, 1'b0, 16'h0, 0);
        check("basic_w0", 64'(m_w[0]), 64'h1200);
        check("basic_w1", 64'(m_w[1]), 64'h0400);
        check("overrun_idle", 64'(bus.overrun), 64'd0);

        // Rounding at the half-LSB boundary
        @(negedge clk);
        apply_reset();
        do_shift(16'h0001);
        do_sweep(16'h0800, 0, 1'b0, 1'b0, 16'h0, 0);
        do_shift(16'hFFFF);
        do_sweep(16'h0800, 0, 1'b0, 1'b0, 16'h0, 0);

        // Overrun: request during sweep is dropped and flagged
        do_shift(16'h2345);
        do_sweep(16'h0321, 2, 1'b0, 1'b0, 16'h0, 0);
        check("overrun_set", 64'(bus.overrun), 64'd1);
        clear_overrun();
        // Clear and new event in the same cycle: event wins
        do_sweep(16'hF100, 3, 1'b1, 1'b0, 16'h0, 0);
        check("overrun_clr_collide", 64'(bus.overrun), 64'd1);
        clear_overrun();

        // Sample and error together: error first, sample after done
        do_sweep(16'h0200, 0, 1'b0, 1'b1, 16'h3000, 0);
        do_sweep(16'h0100, 0, 1'b0, 1'b0, 16'h0, 0);

        // Reset in the middle of a sweep, then a clean sweep from reset
        do_shift(16'h1111);
        do_sweep(16'h0700, 0, 1'b0, 1'b0, 16'h0, 3);
        do_shift(16'h1000);
        do_shift(16'h0800);
        do_sweep(16'h0400, 0, 1'b0, 1'b0, 16'h0, 0);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0)
                do_shift(16'($urandom_range(0, 65535)));
            else
                do_sweep(16'($urandom_range(0, 65535)), 0, 1'b0, 1'b0, 16'h0, 0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_seen), 64'(exp_done));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
